// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath types, FSM encoding and byte-index helpers.
// inv_shift_idx backs the optional INV_SHIFT_ROWS_EN load mapping.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } aes_fsm_t;

    // Byte i (FIPS-197 order, byte 0 in the MSBs) starts at bit 8*(15-i) = {~i, 3'b000}.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

    // Destination byte (r,c) takes source byte (r,(c-r) mod 4); byte index = r + 4*c.
    function automatic logic [3:0] inv_shift_idx(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2];
        return {2'(col - row), row};
    endfunction

endpackage

// File: rtl/sbox_LUT_decrypt.sv
// AES inverse S-box as a pure combinational lookup; entry 0 sits in the MSBs of the table.
module sbox_LUT_decrypt (
    input  logic [7:0] byte_in,
    output logic [7:0] sbyte
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign sbyte = INV_SBOX[{~byte_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_subbytes_serial.sv
// Serial inverse SubBytes: LANES bytes per cycle through sbox_LUT_decrypt, one word in flight.
// Define INV_SHIFT_ROWS_EN to fold InvShiftRows into the input load.
module aes_inv_subbytes_serial
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N     = AES_BYTES / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_fsm_t         fsm_q;
    logic [CNT_W-1:0] cnt_q;
    aes_state_t       state_q;
    aes_state_t       load_word;
    logic [3:0]       lane_idx [LANES];
    aes_byte_t        lane_in  [LANES];
    aes_byte_t        lane_out [LANES];

    always_comb begin
        load_word = in_data;
`ifdef INV_SHIFT_ROWS_EN
        for (int i = 0; i < AES_BYTES; i++) begin
            load_word[byte_lsb(4'(i)) +: 8] = in_data[byte_lsb(inv_shift_idx(4'(i))) +: 8];
        end
`endif
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = 4'(int'(cnt_q) * LANES + k);
            lane_in[k]  = state_q[byte_lsb(lane_idx[k]) +: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_LUT_decrypt u_sbox (
            .byte_in (lane_in[k]),
            .sbyte   (lane_out[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            state_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= load_word;
                        cnt_q    <= '0;
                        fsm_q    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES; k++) begin
                        state_q[byte_lsb(lane_idx[k]) +: 8] <= lane_out[k];
                    end
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_q     <= '0;
                        fsm_q     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign out_data = state_q;

endmodule

// File: tb/tb_aes_inv_subbytes_serial.sv
// Scoreboard bench for aes_inv_subbytes_serial (LANES=1 main DUT plus a LANES=2..16 latency sweep).
`timescale 1ns/1ps
module tb_aes_inv_subbytes_serial;

    localparam int N = 16;
    localparam logic [127:0] VEC       = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef INV_SHIFT_ROWS_EN
    localparam logic [127:0] EXP_VEC   = 128'h000d0a0704010e0b0805020f0c090603;
`else
    localparam logic [127:0] EXP_VEC   = 128'h000102030405060708090a0b0c0d0e0f;
`endif
    localparam logic [127:0] ALL_00    = '0;
    localparam logic [127:0] ALL_52    = {16{8'h52}};
    localparam logic [127:0] ALL_16    = {16{8'h16}};
    localparam logic [127:0] ALL_FF    = {16{8'hff}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_inv_subbytes_serial #(.LANES(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = -100;
    int sweep_done = 0;
    bit sweep_go = 0;
    logic prev_ov = 1'b0;
    logic [127:0] exp_q[$];
    int acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, data on each output handshake.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) check("spurious_out_valid", 1, 0);
                else begin
                    check("latency", cyc - acc_q.pop_front(), N);
                    check("busy_in_done", busy, 1);
                end
            end
            if (out_valid && out_ready) begin
                last_hs = cyc + 1;
                if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output int acc);
        int n = 0;
        @(posedge clk); #1;
        if (push) exp_q.push_back(e);
        in_data  = d;
        in_valid = 1'b1;
        acc = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        check("accept_timeout", (acc >= 0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < max), 1);
    endtask

    // Latency sweep over the other lane counts, one word each, out_ready tied high.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int L = 2 << g;
        logic         iv;
        logic         ir;
        logic         ov;
        logic         bz;
        logic [127:0] od;

        aes_inv_subbytes_serial #(.LANES(L)) u_sweep (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (VEC),
            .out_valid (ov),
            .out_ready (1'b1),
            .out_data  (od),
            .busy      (bz)
        );

        initial begin
            int lat;
            iv = 1'b0;
            wait (sweep_go);
            @(posedge clk); #1;
            iv = 1'b1;
            @(negedge clk);
            check("sweep_in_ready", ir, 1);
            @(posedge clk); #1;
            iv = 1'b0;
            lat = 0;
            while (!ov && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("sweep_latency_L%0d", L), lat, 16 / L);
            check($sformatf("sweep_busy_L%0d", L), bz, 1);
            check($sformatf("sweep_data_L%0d", L), od, EXP_VEC);
            sweep_done++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a;
        int acc_b;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Abort mid-word: reset with cnt==7.
        send(VEC, '0, 1'b0, acc_a);
        check("t1_busy_before", busy, 1);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_in_ready", in_ready, 1);
        check("t1_out_valid", out_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        repeat (20) @(negedge clk);
        check("t1_no_output", out_valid, 0);
        sweep_go = 1'b1;

        // Main vector.
        send(VEC, EXP_VEC, 1'b1, acc_a);
        wait_idle(60);

        // Backpressure with the all-zero corner.
        out_ready = 1'b0;
        send(ALL_00, ALL_52, 1'b1, acc_a);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_valid", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, ALL_52);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            in_valid = i[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_busy", busy, 0);

        // All-0x16 corner.
        send(ALL_16, ALL_FF, 1'b1, acc_a);
        wait_idle(60);

        // Back-to-back with in_valid held high.
        @(posedge clk); #1;
        exp_q.push_back(EXP_VEC);
        in_data  = VEC;
        in_valid = 1'b1;
        acc_a = -1;
        n = 0;
        while (acc_a < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (in_ready) acc_a = cyc + 1;
        end
        check("b2b_first_accept", (acc_a >= 0), 1);
        @(posedge clk); #1;
        exp_q.push_back(ALL_52);
        in_data = ALL_00;
        acc_b = -1;
        n = 0;
        while (acc_b < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (in_ready) acc_b = cyc + 1;
        end
        check("b2b_second_accept", (acc_b >= 0), 1);
        check("b2b_gap", acc_b - last_hs, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(60);

        n = 0;
        while (sweep_done < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("sweep_complete", sweep_done, 4);
        check("scoreboard_drained", exp_q.size(), 0);
        check("accept_queue_drained", acc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
